hazard_unit: RTL and testbench

- Pipeline hazard unit for the 5-stage MIPS core.
- Consumes the register numbers and the control bits produced by the decode-stage controller as they move through the D/E/M/W pipeline registers.
- Produces the forwarding selects, the stall/flush controls (including the flushE that clears the D/E control register), and variable-latency data-memory stall handling.
- Also provides a memory-timeout error flag and a saturating stall-cycle performance counter.

---
 rtl/hazard_unit.sv | 202 ++++++++++++++++++++
 tb/tb_hazard_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage MIPS core: operand forwarding, load-use and
// branch interlocks, variable-latency data-memory stalls with a timeout
// flag, and a saturating count of front-end stall cycles.

// One forwarding lane per source operand (rs, rt). Each lane gives the
// Execute ALU mux select and the Decode branch-comparator forward.
module hazardFwdLane (
  input  logic [4:0] srcE,
  input  logic [4:0] srcD,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteM,
  input  logic       regwriteW,
  output logic [1:0] fwdE,
  output logic       fwdD
);

  // M has the younger value, so it wins over W; $0 is hardwired and never forwarded
  always_comb begin
    fwdE = 2'b00;
    if (srcE != 5'd0 && srcE == writeregM && regwriteM)
      fwdE = 2'b10;
    else if (srcE != 5'd0 && srcE == writeregW && regwriteW)
      fwdE = 2'b01;
    fwdD = (srcD != 5'd0) && (srcD == writeregM) && regwriteM;
  end

endmodule

module hazard_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             branchD,
  input  logic             memreqM,
  input  logic             memreadyM,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushE,
  output logic             flushW,
  output logic             memerr,
  output logic [CNT_W-1:0] stallcnt
);

  localparam int NUM_SRC = 2;
  localparam int WCW     = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0]   WMAX = WCW'(TIMEOUT);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushE;
    logic flushW;
  } ctl_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // ---------------- forwarding ----------------
  logic [NUM_SRC-1:0][4:0] srcE, srcD;
  logic [NUM_SRC-1:0][1:0] fwdE;
  logic [NUM_SRC-1:0]      fwdD;

  assign srcE = {rtE, rsE};
  assign srcD = {rtD, rsD};

  for (genvar i = 0; i < NUM_SRC; i++) begin : gLane
    hazardFwdLane uLane (
      .srcE      (srcE[i]),
      .srcD      (srcD[i]),
      .writeregM (writeregM),
      .writeregW (writeregW),
      .regwriteM (regwriteM),
      .regwriteW (regwriteW),
      .fwdE      (fwdE[i]),
      .fwdD      (fwdD[i])
    );
  end

  assign forwardAE = fwdE[0];
  assign forwardBE = fwdE[1];
  assign forwardAD = fwdD[0];
  assign forwardBD = fwdD[1];

  // ---------------- hazard detection ----------------
  logic lwstall, branchstall, memstall;
  ctl_t ctl;

  // Raw hazard terms from the pipeline-register contents
  always_comb begin
    lwstall     = memtoregE && (rtE == rsD || rtE == rtD);
    branchstall = branchD &&
                  ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                   (memtoregM && (writeregM == rsD || writeregM == rtD)));
    memstall    = memreqM && !memreadyM;
  end

  // Memory stall freezes everything up to M and bubbles W; it overrides the
  // D-stage interlocks, which re-evaluate once the access completes.
  always_comb begin
    ctl = '0;
    if (memstall) begin
      ctl.stallF = 1'b1;
      ctl.stallD = 1'b1;
      ctl.stallE = 1'b1;
      ctl.stallM = 1'b1;
      ctl.flushW = 1'b1;
    end else if (lwstall || branchstall) begin
      ctl.stallF = 1'b1;
      ctl.stallD = 1'b1;
      ctl.flushE = 1'b1;
    end
  end

  assign stallF = ctl.stallF;
  assign stallD = ctl.stallD;
  assign stallE = ctl.stallE;
  assign stallM = ctl.stallM;
  assign flushE = ctl.flushE;
  assign flushW = ctl.flushW;

  // ---------------- memory wait FSM ----------------
  state_t         state, stateNext;
  logic [WCW-1:0] waitcnt, waitcntNext;
  logic           memerrNext;

  // State, wait counter and sticky error register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      waitcnt <= '0;
      memerr  <= 1'b0;
    end else begin
      state   <= stateNext;
      waitcnt <= waitcntNext;
      memerr  <= memerrNext;
    end
  end

  // Count wait cycles; a wait still pending at TIMEOUT latches memerr but
  // the access is not aborted -- the stall continues until memory answers.
  always_comb begin
    stateNext   = state;
    waitcntNext = waitcnt;
    memerrNext  = memerr;
    unique case (state)
      S_IDLE: begin
        if (memstall) begin
          stateNext   = S_WAIT;
          waitcntNext = WCW'(1);
        end
      end
      S_WAIT: begin
        if (memstall) begin
          if (waitcnt == WMAX)
            memerrNext = 1'b1;
          else
            waitcntNext = waitcnt + WCW'(1);
        end else begin
          stateNext   = S_IDLE;
          waitcntNext = '0;
        end
      end
      default: begin
        stateNext   = S_IDLE;
        waitcntNext = '0;
      end
    endcase
  end

  // ---------------- stall-cycle counter ----------------
  // Saturates rather than wrapping so a long run never looks short
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stallcnt <= '0;
    else if (stallF && stallcnt != CMAX)
      stallcnt <= stallcnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// traffic against a rule-level reference model.
module tb_hazard_unit;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 5;
  localparam int CMAXI   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic             regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic             branchD, memreqM, memreadyM;
  logic             forwardAD, forwardBD;
  logic [1:0]       forwardAE, forwardBE;
  logic             stallF, stallD, stallE, stallM, flushE, flushW, memerr;
  logic [CNT_W-1:0] stallcnt;

  int total = 0;
  int bad   = 0;

  // model state: consecutive memory-stall run, sticky error, stall count
  int mRun = 0;
  bit mErr = 0;
  int mCnt = 0;

  always #5 clk = ~clk;

  hazard_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
    .memreqM(memreqM), .memreadyM(memreadyM),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushE(flushE), .flushW(flushW), .memerr(memerr), .stallcnt(stallcnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Execute select: newest producer (M) first, then W; $0 never forwarded
  function automatic logic [1:0] refFwdE(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (regwriteM && writeregM == src) return 2'b10;
    if (regwriteW && writeregW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit refFwdD(input logic [4:0] src);
    return src != 0 && regwriteM && writeregM == src;
  endfunction

  function automatic bit refMem();
    return memreqM && !memreadyM;
  endfunction

  function automatic bit refIlock();
    bit lw, br;
    lw = memtoregE && (rtE == rsD || rtE == rtD);
    br = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                     (memtoregM && (writeregM == rsD || writeregM == rtD)));
    return lw || br;
  endfunction

  // expected {stallF,stallD,stallE,stallM,flushE,flushW}
  function automatic logic [5:0] refCtl();
    if (refMem())   return 6'b111101;
    if (refIlock()) return 6'b110010;
    return 6'b000000;
  endfunction

  task automatic checkComb();
    chk("fwdAE", forwardAE, refFwdE(rsE));
    chk("fwdBE", forwardBE, refFwdE(rtE));
    chk("fwdAD", forwardAD, refFwdD(rsD));
    chk("fwdBD", forwardBD, refFwdD(rtD));
    chk("ctl", {stallF, stallD, stallE, stallM, flushE, flushW}, refCtl());
  endtask

  // what the coming rising edge should do to the registered state
  task automatic advance();
    if (!reset) begin
      mRun = 0; mErr = 0; mCnt = 0;
      return;
    end
    if (refMem()) begin
      mRun++;
      if (mRun > TIMEOUT) mErr = 1;
    end else begin
      mRun = 0;
    end
    if ((refMem() || refIlock()) && mCnt < CMAXI) mCnt++;
  endtask

  // inputs are set just after a falling edge; check, clock, check registers
  task automatic tick();
    #1;
    checkComb();
    advance();
    @(negedge clk);
    chk("memerr", memerr, mErr);
    chk("stallcnt", stallcnt, mCnt);
  endtask

  task automatic idle();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0; branchD = 0;
    memreqM = 0; memreadyM = 0;
  endtask

  task automatic doReset();
    reset = 0;
    tick();
    reset = 1;
  endtask

  int c0;

  initial begin
    idle();
    reset = 0;
    #3;
    chk("rst_memerr", memerr, 0);
    chk("rst_cnt", stallcnt, 0);
    @(negedge clk);
    reset = 1;
    tick();

    // forwarding priority
    writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1; rsE = 5;
    tick();
    chk("fwd_m_prio", forwardAE, 2'b10);
    regwriteM = 0;
    tick();
    chk("fwd_w", forwardAE, 2'b01);
    rsE = 0; writeregM = 0; regwriteM = 1;
    tick();
    chk("fwd_r0", forwardAE, 2'b00);
    idle();

    // load-use
    c0 = stallcnt;
    memtoregE = 1; rtE = 8; rsD = 8;
    repeat (3) tick();
    chk("lu_cnt", stallcnt - c0, 3);
    idle();

    // branch hazard then forward from M
    branchD = 1; regwriteE = 1; writeregE = 3; rtD = 3;
    tick();
    regwriteE = 0; writeregE = 0;
    memtoregM = 0; regwriteM = 1; writeregM = 3;
    #1;
    chk("br_fwdBD", forwardBD, 1);
    chk("br_nostall", stallF, 0);
    tick();
    idle();

    // memory wait of 3 cycles
    doReset();
    memreqM = 1; memreadyM = 0;
    repeat (3) tick();
    memreadyM = 1;
    tick();
    chk("mw_cnt", stallcnt, 3);
    chk("mw_err", memerr, 0);
    idle();

    // timeout: 6 not-ready cycles, memerr after TIMEOUT wait cycles
    memreqM = 1; memreadyM = 0;
    repeat (TIMEOUT) tick();
    chk("to_early", memerr, 0);
    tick();
    chk("to_set", memerr, 1);
    tick();
    memreadyM = 1;
    tick();
    chk("to_sticky", memerr, 1);
    // async reset mid-wait, no clock edge
    memreadyM = 0;
    tick();
    tick();
    #2;
    reset = 0;
    #1;
    chk("ar_err", memerr, 0);
    chk("ar_cnt", stallcnt, 0);
    mRun = 0; mErr = 0; mCnt = 0;
    @(negedge clk);
    reset = 1;
    // state back in IDLE: a fresh wait needs the full count again
    repeat (TIMEOUT) tick();
    chk("ar_idle", memerr, 0);
    idle();
    doReset();

    // priority memstall over lwstall
    memreqM = 1; memreadyM = 0; memtoregE = 1; rtE = 9; rsD = 9;
    #1;
    chk("pr_flushE", flushE, 0);
    chk("pr_flushW", flushW, 1);
    chk("pr_stallE", stallE, 1);
    tick();
    memreadyM = 1;
    #1;
    chk("pr_lw", {flushE, stallE, flushW}, 3'b100);
    tick();
    idle();

    // randomized traffic, small register space to provoke matches
    for (int n = 0; n < 600; n++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
      memtoregE = ($urandom_range(0, 3) == 0);
      memtoregM = ($urandom_range(0, 3) == 0);
      branchD   = ($urandom_range(0, 3) == 0);
      memreqM   = ($urandom_range(0, 1) == 0);
      memreadyM = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 99) != 0);
      tick();
    end
    reset = 1;
    idle();

    // drive the counter into saturation
    memtoregE = 1; rtE = 1; rsD = 1;
    repeat (CMAXI + 4) tick();
    chk("sat_cnt", stallcnt, CMAXI);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
